// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared system definitions for the memory subsystem: bus command encoding,
//   requester identity, default widths and small helpers used by the arbiter,
//   its tag table and the cache/memory port interface.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  localparam int unsigned DEF_XLEN  = 32;  // requester address width
  localparam int unsigned DEF_TAG_W = 4;   // memory tag width, tag 0 = none
  localparam int unsigned DATA_W    = 64;  // memory data word width

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_cmd_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } req_src_t;

  // Saturating 4-bit increment used by the starvation counter.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   One tagged memory port as seen by a cache: command/addr/data going towards
//   memory and response/data/tag coming back.
//   master : the requester side (drives proc2mem_*, receives mem2proc_*)
//   slave  : the responder side (receives proc2mem_*, drives mem2proc_*)
//   Signals:
//     proc2mem_command  BUS_NONE/BUS_LOAD/BUS_STORE
//     proc2mem_addr     XLEN-bit line address
//     proc2mem_data     64-bit store data
//     mem2proc_response TAG_W accept tag, 0 = not accepted
//     mem2proc_data     64-bit returning load data
//     mem2proc_tag      TAG_W tag of returning data, 0 = none
// -----------------------------------------------------------------------------
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned XLEN  = DEF_XLEN,
  parameter int unsigned TAG_W = DEF_TAG_W
) ();

  bus_cmd_t              proc2mem_command;
  logic [XLEN-1:0]       proc2mem_addr;
  logic [DATA_W-1:0]     proc2mem_data;
  logic [TAG_W-1:0]      mem2proc_response;
  logic [DATA_W-1:0]     mem2proc_data;
  logic [TAG_W-1:0]      mem2proc_tag;

  modport master (
    output proc2mem_command,
    output proc2mem_addr,
    output proc2mem_data,
    input  mem2proc_response,
    input  mem2proc_data,
    input  mem2proc_tag
  );

  modport slave (
    input  proc2mem_command,
    input  proc2mem_addr,
    input  proc2mem_data,
    output mem2proc_response,
    output mem2proc_data,
    output mem2proc_tag
  );

endinterface

// File: rtl/mem_tag_table.sv
// -----------------------------------------------------------------------------
// mem_tag_table
//   Ownership table for outstanding load tags 1..2^TAG_W-1. Each entry holds a
//   valid bit and the requester (SRC_I/SRC_D) that owns the tag.
//   Ports:
//     clk, reset    clock / asynchronous active-high reset (clears valid bits)
//     i_set_en      record a new accept at i_set_tag owned by i_set_owner
//     i_set_tag     tag to record (tag 0 is ignored)
//     i_set_owner   owning requester
//     i_lkp_tag     tag to look up (returning data tag)
//     i_clr_en      retire the looked-up entry at the next edge if it hits
//     o_hit         looked-up tag is nonzero and outstanding
//     o_owner       owner of the looked-up tag (meaningful when o_hit)
// -----------------------------------------------------------------------------
module mem_tag_table
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TAG_W = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_set_en,
  input  logic [TAG_W-1:0] i_set_tag,
  input  req_src_t         i_set_owner,
  input  logic [TAG_W-1:0] i_lkp_tag,
  input  logic             i_clr_en,
  output logic             o_hit,
  output req_src_t         o_owner
);

  localparam int unsigned DEPTH = 1 << TAG_W;

  logic [DEPTH-1:0] r_valid;
  req_src_t         r_owner [DEPTH];

  assign o_hit   = (i_lkp_tag != '0) && r_valid[i_lkp_tag];
  assign o_owner = r_owner[i_lkp_tag];

  // Clear is applied before set so that a tag returned and re-accepted in the
  // same cycle ends up valid with the new owner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else begin
      if (i_clr_en && o_hit) begin
        r_valid[i_lkp_tag] <= 1'b0;
      end
      if (i_set_en && (i_set_tag != '0)) begin
        r_valid[i_set_tag] <= 1'b1;
      end
    end
  end

  // Owner bits are only meaningful under a valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    if (i_set_en && (i_set_tag != '0)) begin
      r_owner[i_set_tag] <= i_set_owner;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares the single tagged memory port between icache and dcache. One
//   requester is granted per cycle (combinationally) and its command/addr/data
//   are forwarded; the memory accept tag is routed back to the granted side
//   only. Outstanding load tags are tracked so returning data tags reach only
//   their owner. dcache has priority unless icache has been denied
//   STARVE_LIMIT consecutive requesting cycles.
//   Ports:
//     clk        clock, all state updates on posedge
//     reset      asynchronous active-high reset
//     icache     slave port facing the icache (loads only)
//     dcache     slave port facing the dcache (loads and stores)
//     mem        master port facing memory
//     tag_error  sticky: a nonzero return tag arrived with no outstanding owner
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned XLEN         = DEF_XLEN,
  parameter int unsigned TAG_W        = DEF_TAG_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.slave   icache,
  mem_arbiter_if.slave   dcache,
  mem_arbiter_if.master  mem,
  output logic           tag_error
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic            w_i_req;
  logic            w_d_req;
  logic            w_grant_i;
  logic            w_grant_d;
  bus_cmd_t        w_cmd;
  logic [XLEN-1:0] w_addr;
  logic            w_resp_nz;
  logic            w_accept;
  req_src_t        w_set_owner;
  logic            w_hit;
  req_src_t        w_owner;
  logic [3:0]      r_starve;
  logic            r_tag_error;
  logic            w_unused_idata;

  // icache never stores, so its data lane is intentionally ignored.
  assign w_unused_idata = ^icache.proc2mem_data;

  assign w_i_req   = (icache.proc2mem_command != BUS_NONE);
  assign w_d_req   = (dcache.proc2mem_command != BUS_NONE);
  assign w_resp_nz = (mem.mem2proc_response != '0);

  // Grant, forwarding and accept decode.
  always_comb begin
    w_grant_d   = w_d_req && (!w_i_req || (r_starve < LIMIT));
    w_grant_i   = !w_grant_d && w_i_req;
    w_cmd       = BUS_NONE;
    w_addr      = '0;
    w_set_owner = SRC_I;
    if (w_grant_d) begin
      w_cmd       = dcache.proc2mem_command;
      w_addr      = dcache.proc2mem_addr;
      w_set_owner = SRC_D;
    end else if (w_grant_i) begin
      w_cmd       = icache.proc2mem_command;
      w_addr      = icache.proc2mem_addr;
    end
    w_accept = (w_cmd == BUS_LOAD) && w_resp_nz;
  end

  assign mem.proc2mem_command = w_cmd;
  assign mem.proc2mem_addr    = w_addr;
  assign mem.proc2mem_data    = w_grant_d ? dcache.proc2mem_data : '0;

  assign icache.mem2proc_response = w_grant_i ? mem.mem2proc_response : '0;
  assign dcache.mem2proc_response = w_grant_d ? mem.mem2proc_response : '0;

  assign icache.mem2proc_data = mem.mem2proc_data;
  assign dcache.mem2proc_data = mem.mem2proc_data;

  // Return tags are visible only to the recorded owner.
  assign icache.mem2proc_tag = (w_hit && (w_owner == SRC_I)) ? mem.mem2proc_tag : '0;
  assign dcache.mem2proc_tag = (w_hit && (w_owner == SRC_D)) ? mem.mem2proc_tag : '0;

  assign tag_error = r_tag_error;

  mem_tag_table #(
    .TAG_W (TAG_W)
  ) u_tag_table (
    .clk         (clk),
    .reset       (reset),
    .i_set_en    (w_accept),
    .i_set_tag   (mem.mem2proc_response),
    .i_set_owner (w_set_owner),
    .i_lkp_tag   (mem.mem2proc_tag),
    .i_clr_en    (1'b1),
    .o_hit       (w_hit),
    .o_owner     (w_owner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve    <= '0;
      r_tag_error <= 1'b0;
    end else begin
      if (w_i_req && !w_grant_i) begin
        r_starve <= sat_inc4(r_starve, LIMIT);
      end else if (w_grant_i && w_resp_nz) begin
        r_starve <= '0;
      end
      if ((mem.mem2proc_tag != '0) && !w_hit) begin
        r_tag_error <= 1'b1;
      end
    end
  end

endmodule
